// File: rtl/inst_trace_pkg.sv
// Shared definitions for the retired-instruction trace FIFO: record width,
// field offsets inside a record, and the packed record layout.
package inst_trace_pkg;

  localparam int DATA_W    = 70;
  localparam int PC_LSB    = 0;
  localparam int WDATA_LSB = 32;
  localparam int WADDR_LSB = 64;
  localparam int WEN_BIT   = 69;

  // One retired instruction, MSB first: {rf_wen, rf_waddr, rf_wdata, pc}
  typedef struct packed {
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pc;
  } inst_rec_t;

endpackage

// File: rtl/inst_retired_fifo_ram.sv
// Trace storage: DEPTH x DATA_W array with one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module inst_retired_fifo_ram #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = inst_trace_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the incoming record on the rising edge when the push is accepted
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Head entry is read combinationally so it is ready the cycle after a push
  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_retired_fifo.sv
// Retired-instruction trace FIFO. The CPU pushes one record per retired
// instruction; a trace consumer drains it with a valid/ready handshake.
// Pushes into a full FIFO are dropped and latch a sticky overflow flag.
// Optional feature macro: INST_RETIRED_FIFO_STAT_EN enables the 32-bit
// accepted/dropped push counters; without it both stat outputs read 0.
module inst_retired_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = inst_trace_pkg::DATA_W
) (
  input  logic                     cpu_clk,
  input  logic                     cpu_reset_n,
  input  logic                     inst_retired_valid,
  input  logic [DATA_W-1:0]        inst_retired_data,
  output logic                     inst_retired_fifo_full,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [DATA_W-1:0]        trace_data,
  output logic [$clog2(DEPTH):0]   trace_count,
  output logic                     overflow,
  output logic [31:0]              stat_push_cnt,
  output logic [31:0]              stat_drop_cnt
);

  import inst_trace_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full;
  logic          push_acc;
  logic          pop;

  // Flags come only from the registered count, so full never depends on trace_ready
  assign full                   = (count_q == FULL_CNT);
  assign inst_retired_fifo_full = full;
  assign trace_valid            = (count_q != '0);
  assign trace_count            = count_q;
  assign overflow               = overflow_q;

  inst_retired_fifo_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (cpu_clk),
    .we    (push_acc),
    .waddr (wr_ptr_q),
    .wdata (inst_retired_data),
    .raddr (rd_ptr_q),
    .rdata (trace_data)
  );

  // Next-state: a full FIFO drops the push even if a pop frees a slot this cycle
  always_comb begin
    push_acc   = inst_retired_valid && !full;
    pop        = trace_valid && trace_ready;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (inst_retired_valid && full);
    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy and sticky overflow registers, cleared asynchronously
  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef INST_RETIRED_FIFO_STAT_EN
  logic [31:0] push_cnt_q, push_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  // Statistics: count accepted and dropped pushes, wrapping at 2^32
  always_comb begin
    push_cnt_d = push_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (push_acc) begin
      push_cnt_d = push_cnt_q + 32'd1;
    end
    if (inst_retired_valid && full) begin
      drop_cnt_d = drop_cnt_q + 32'd1;
    end
  end

  // Statistic registers share the FIFO's asynchronous reset
  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      push_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      push_cnt_q <= push_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign stat_push_cnt = push_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;
`else
  assign stat_push_cnt = 32'd0;
  assign stat_drop_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_inst_retired_fifo.sv
// Directed self-checking bench for inst_retired_fifo (DEPTH=16). Expected
// statistics depend on whether INST_RETIRED_FIFO_STAT_EN is defined.
module tb_inst_retired_fifo;

  import inst_trace_pkg::*;

  localparam int DEPTH = 16;
`ifdef INST_RETIRED_FIFO_STAT_EN
  localparam int STAT_ON = 1;
`else
  localparam int STAT_ON = 0;
`endif

  logic              cpu_clk;
  logic              cpu_reset_n;
  logic              inst_retired_valid;
  logic [DATA_W-1:0] inst_retired_data;
  logic              inst_retired_fifo_full;
  logic              trace_valid;
  logic              trace_ready;
  logic [DATA_W-1:0] trace_data;
  logic [4:0]        trace_count;
  logic              overflow;
  logic [31:0]       stat_push_cnt;
  logic [31:0]       stat_drop_cnt;

  int checks = 0;
  int errors = 0;

  inst_retired_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .cpu_clk                (cpu_clk),
    .cpu_reset_n            (cpu_reset_n),
    .inst_retired_valid     (inst_retired_valid),
    .inst_retired_data      (inst_retired_data),
    .inst_retired_fifo_full (inst_retired_fifo_full),
    .trace_valid            (trace_valid),
    .trace_ready            (trace_ready),
    .trace_data             (trace_data),
    .trace_count            (trace_count),
    .overflow               (overflow),
    .stat_push_cnt          (stat_push_cnt),
    .stat_drop_cnt          (stat_drop_cnt)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // Build a distinctive record from a pc so every field carries information
  function automatic logic [DATA_W-1:0] mk(input logic [31:0] pc);
    inst_rec_t r;
    r.rf_wen   = pc[2];
    r.rf_waddr = pc[6:2];
    r.rf_wdata = ~pc;
    r.pc       = pc;
    return r;
  endfunction

  // Drive one cycle of inputs, then settle 1 ns past the rising edge
  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic r);
    inst_retired_valid = v;
    inst_retired_data  = d;
    trace_ready        = r;
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkFlags(input string tag, input logic v, input logic f, input int cnt, input logic ov);
    checkOutput({tag, ".valid"}, DATA_W'(trace_valid), DATA_W'(v));
    checkOutput({tag, ".full"}, DATA_W'(inst_retired_fifo_full), DATA_W'(f));
    checkOutput({tag, ".count"}, DATA_W'(trace_count), DATA_W'(cnt));
    checkOutput({tag, ".overflow"}, DATA_W'(overflow), DATA_W'(ov));
  endtask

  initial begin
    $display("[TB] start, STAT_ON=%0d", STAT_ON);
    cpu_reset_n        = 1'b0;
    inst_retired_valid = 1'b0;
    inst_retired_data  = '0;
    trace_ready        = 1'b0;
    repeat (3) @(posedge cpu_clk);
    #1;
    checkFlags("reset", 1'b0, 1'b0, 0, 1'b0);
    checkOutput("reset.push_cnt", DATA_W'(stat_push_cnt), '0);
    checkOutput("reset.drop_cnt", DATA_W'(stat_drop_cnt), '0);

    // Release reset away from the edge; the very next edge must accept a push
    @(negedge cpu_clk);
    cpu_reset_n = 1'b1;
    applyStimulus(1'b1, mk(32'h0000_0100), 1'b0);
    checkFlags("first_push", 1'b1, 1'b0, 1, 1'b0);
    checkOutput("first_push.pc", DATA_W'(trace_data[31:0]), DATA_W'(32'h100));
    checkOutput("first_push.data", trace_data, mk(32'h0000_0100));

    // Pop it, then a pop request on an empty FIFO must change nothing
    applyStimulus(1'b0, '0, 1'b1);
    checkFlags("pop_to_empty", 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    checkFlags("pop_empty", 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, mk(32'h0000_0200), 1'b0);
    checkFlags("push_after_empty_pop", 1'b1, 1'b0, 1, 1'b0);
    checkOutput("push_after_empty_pop.data", trace_data, mk(32'h0000_0200));
    applyStimulus(1'b0, '0, 1'b1);
    checkFlags("drain_one", 1'b0, 1'b0, 0, 1'b0);

    // Fill with 16 entries, no consumer
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, mk(32'h1000 + 32'(i * 4)), 1'b0);
      if (i == DEPTH - 2) checkFlags("fill15", 1'b1, 1'b0, 15, 1'b0);
    end
    checkFlags("fill16", 1'b1, 1'b1, 16, 1'b0);
    checkOutput("fill16.head", trace_data, mk(32'h1000));

    // Idle with the consumer stalled: head holds
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("stall.head", trace_data, mk(32'h1000));
    checkFlags("stall", 1'b1, 1'b1, 16, 1'b0);

    // 17th push is dropped
    applyStimulus(1'b1, mk(32'hDEAD_0000), 1'b0);
    checkFlags("drop", 1'b1, 1'b1, 16, 1'b1);
    checkOutput("drop.head", trace_data, mk(32'h1000));
    checkOutput("drop.drop_cnt", DATA_W'(stat_drop_cnt), DATA_W'(STAT_ON ? 1 : 0));

    // Push + pop while full: pop happens, push dropped
    applyStimulus(1'b1, mk(32'h0000_0BAD), 1'b1);
    checkFlags("full_push_pop", 1'b1, 1'b0, 15, 1'b1);
    checkOutput("full_push_pop.drop_cnt", DATA_W'(stat_drop_cnt), DATA_W'(STAT_ON ? 2 : 0));

    // Drain the remaining 15 in order; the dropped 0xBAD must never appear
    for (int i = 1; i < DEPTH; i++) begin
      checkOutput($sformatf("drain%0d.data", i), trace_data, mk(32'h1000 + 32'(i * 4)));
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkFlags("drained", 1'b0, 1'b0, 0, 1'b1);
    checkOutput("drained.push_cnt", DATA_W'(stat_push_cnt), DATA_W'(STAT_ON ? 18 : 0));
    checkOutput("drained.drop_cnt", DATA_W'(stat_drop_cnt), DATA_W'(STAT_ON ? 2 : 0));

    // Streaming push+pop: occupancy stays 1, order preserved, pointers wrap
    applyStimulus(1'b1, mk(32'h0), 1'b0);
    checkFlags("stream_start", 1'b1, 1'b0, 1, 1'b1);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1, mk(32'((k + 1) * 4)), 1'b1);
      checkOutput($sformatf("stream%0d.count", k), DATA_W'(trace_count), DATA_W'(1));
      checkOutput($sformatf("stream%0d.data", k), trace_data, mk(32'((k + 1) * 4)));
    end

    // Build occupancy up to 7, then reset asynchronously mid-cycle during a push
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, mk(32'h3000 + 32'(i * 4)), 1'b0);
    end
    checkFlags("pre_reset", 1'b1, 1'b0, 7, 1'b1);
    checkOutput("pre_reset.head", trace_data, mk(32'd160));
    inst_retired_valid = 1'b1;
    inst_retired_data  = mk(32'h4000);
    #2;
    cpu_reset_n = 1'b0;
    #1;
    checkFlags("async_reset", 1'b0, 1'b0, 0, 1'b0);
    checkOutput("async_reset.push_cnt", DATA_W'(stat_push_cnt), '0);
    checkOutput("async_reset.drop_cnt", DATA_W'(stat_drop_cnt), '0);

    // Hold reset across edges, release, and push once more
    inst_retired_valid = 1'b0;
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    cpu_reset_n = 1'b1;
    applyStimulus(1'b1, mk(32'h0000_0500), 1'b0);
    checkFlags("post_reset_push", 1'b1, 1'b0, 1, 1'b0);
    checkOutput("post_reset_push.data", trace_data, mk(32'h0000_0500));
    checkOutput("post_reset_push.push_cnt", DATA_W'(stat_push_cnt), DATA_W'(STAT_ON ? 1 : 0));
    applyStimulus(1'b0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_retired_fifo.md
INST_RETIRED_FIFO -- requirements
Module: inst_retired_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of trace entries; power of two, 4..256.
REQ-002 SHALL have parameter DATA_W, default 70, entry width = {rf_wen[69], rf_waddr[68:64], rf_wdata[63:32], pc[31:0]}.
REQ-003 SHALL have port cpu_clk  in  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port cpu_reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port inst_retired_valid  in  1  CPU retires one instruction this cycle.
REQ-006 SHALL have port inst_retired_data  in  DATA_W  retired-instruction record.
REQ-007 SHALL have port inst_retired_fifo_full  out  1  back-pressure to CPU; high when count == DEPTH.
REQ-008 SHALL have port trace_valid  out  1  head entry available to the trace consumer.
REQ-009 SHALL have port trace_ready  in  1  consumer accepts the head entry.
REQ-010 SHALL have port trace_data  out  DATA_W  head entry.
REQ-011 SHALL have port trace_count  out  $clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port overflow  out  1  sticky: a push was dropped.
REQ-013 SHALL have port stat_push_cnt  out  32  accepted pushes.
REQ-014 SHALL have port stat_drop_cnt  out  32  dropped pushes.

Function
REQ-015 Push SHALL be accepted when inst_retired_valid=1 and count < DEPTH; the entry is written at wr_ptr and wr_ptr advances modulo DEPTH.
REQ-016 Pop SHALL occur when trace_valid=1 and trace_ready=1; rd_ptr advances modulo DEPTH.
REQ-017 trace_valid SHALL equal (count != 0); trace_data SHALL equal mem[rd_ptr]; no fall-through, so a push into an empty FIFO is visible exactly 1 cycle later.
REQ-018 Simultaneous accepted push and pop SHALL leave count unchanged.
REQ-019 When full, a push SHALL be dropped even if a pop happens in the same cycle; overflow is set and remains 1 until reset.
REQ-020 A pop request with count == 0 SHALL be ignored, with no pointer or count change.
REQ-021 inst_retired_fifo_full SHALL be derived from registered count only (no combinational path from trace_ready).
REQ-022 Pointers SHALL be $clog2(DEPTH) bits wide and wrap naturally; count saturates at neither 0 nor DEPTH by construction.
REQ-023 trace_data SHALL hold stable while trace_valid=1 and trace_ready=0.

Reset
REQ-024 On cpu_reset_n=0 (any time, including mid-push), the block SHALL asynchronously clear wr_ptr, rd_ptr, count, overflow and both stat counters to 0.
REQ-025 The reset outputs SHALL be: trace_valid=0, inst_retired_fifo_full=0, trace_count=0, overflow=0; storage contents are not reset.
REQ-026 The first push SHALL be accepted on the first rising edge after cpu_reset_n deasserts.

Configuration
REQ-027 Macro INST_RETIRED_FIFO_STAT_EN defined: stat_push_cnt increments per accepted push and stat_drop_cnt per dropped push; both are 32-bit and wrap at 2^32.
REQ-028 Macro undefined: the counters are not instantiated, and stat_push_cnt and stat_drop_cnt are tied to 0; all other behaviour is identical.

Structure
REQ-029 Package inst_trace_pkg SHALL hold DATA_W, the field bit offsets (PC_LSB, WDATA_LSB, WADDR_LSB, WEN_BIT), and the trace-record struct typedef.
REQ-030 Storage SHALL be the sub-module inst_retired_fifo_ram: 1 synchronous write port and 1 asynchronous read port, DEPTH x DATA_W, no reset.
REQ-031 Pointer, count, flag and stat logic SHALL reside in inst_retired_fifo.

Verification
REQ-032 Reset then 1 push of pc=0x00000100, trace_ready=0 -> trace_valid=1 next cycle, trace_data[31:0]=0x100, trace_count=1.
REQ-033 16 pushes with trace_ready=0 (DEPTH=16) -> inst_retired_fifo_full=1 after the 16th, count=16; a 17th push is dropped, overflow=1, stat_drop_cnt=1 (macro on).
REQ-034 Full FIFO, push+pop in the same cycle -> count=15, full=0, the pushed entry is absent, overflow=1.
REQ-035 Continuous push+pop of pc=0,4,8,... for 40 cycles -> output order is identical to input, count stays 1, and the pointers wrap twice without error.
REQ-036 Assert cpu_reset_n=0 mid-stream with count=7 -> all outputs return to reset values immediately, without waiting for a clock edge.
REQ-037 Macro off, 20 pushes -> stat_push_cnt=0 and stat_drop_cnt=0; macro on -> stat_push_cnt=16 (DEPTH=16, no pops).
